// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between N_REQ byte-stream requesters. Grants
// are round-robin and message-atomic: an owner keeps the transmitter until it
// marks the last byte, hits the per-grant burst limit, or leaves valid low for
// STALL_MAX cycles. Each accepted byte is sequenced through the transmitter's
// start/busy handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   req_valid  in   [N_REQ]          requester i presents a byte
//   req_data   in   [N_REQ*DATA_W]   requester i byte at [i*DATA_W +: DATA_W]
//   req_last   in   [N_REQ]          presented byte ends the message
//   req_ready  out  [N_REQ]          byte accepted this cycle (one-hot or zero)
//   tx_data    out  [DATA_W]         byte to transmitter, held between starts
//   tx_start   out                   one-cycle start pulse to transmitter
//   tx_busy    in                    transmitter shifting a frame
//   grant      out  [N_REQ]          one-hot current owner, zero when idle
//   active     out                   a grant is held
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned STALL_MAX = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic [N_REQ-1:0]         grant,
    output logic                     active
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0]  BURST_LIM = 8'(MAX_BURST);
    localparam logic [9:0]  STALL_LIM = 10'(STALL_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e             state_q;
    logic [N_REQ-1:0]   grant_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [7:0]         burst_cnt_q;
    logic [9:0]         stall_cnt_q;
    logic               last_flag_q;
    logic [DATA_W-1:0]  tx_data_q;
    logic               tx_start_q;

    // Round-robin pick
    logic               pick_vld_d;
    logic [IDX_W-1:0]   pick_idx_d;
    logic [N_REQ-1:0]   pick_onehot_d;
    int unsigned        scan_idx;

    // Owner view
    logic               own_valid;
    logic               own_last;
    logic [DATA_W-1:0]  own_data;
    logic               accept;

    // Scan from the farthest position down to rr_ptr+1 so the closest valid
    // requester after the previous owner is written last and wins.
    always_comb begin
        pick_vld_d    = 1'b0;
        pick_idx_d    = '0;
        pick_onehot_d = '0;
        scan_idx      = 0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            scan_idx = (32'(rr_ptr_q) + k) % N_REQ;
            if (req_valid[scan_idx]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = IDX_W'(scan_idx);
            end
        end
        if (pick_vld_d) begin
            pick_onehot_d[pick_idx_d] = 1'b1;
        end
    end

    assign own_valid = req_valid[owner_q];
    assign own_last  = req_last[owner_q];
    assign own_data  = req_data[owner_q*DATA_W +: DATA_W];

    // A byte is taken only while the owner is valid and the line is free.
    assign accept = (state_q == SEND) && own_valid && !tx_busy;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= IDX_W'(N_REQ - 1);
            burst_cnt_q <= '0;
            stall_cnt_q <= '0;
            last_flag_q <= 1'b0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        grant_q     <= pick_onehot_d;
                        owner_q     <= pick_idx_d;
                        burst_cnt_q <= '0;
                        stall_cnt_q <= '0;
                        state_q     <= SEND;
                    end
                end

                SEND: begin
                    if (accept) begin
                        tx_data_q   <= own_data;
                        tx_start_q  <= 1'b1;
                        last_flag_q <= own_last;
                        burst_cnt_q <= (burst_cnt_q == 8'hFF) ? burst_cnt_q
                                                              : burst_cnt_q + 8'd1;
                        stall_cnt_q <= '0;
                        state_q     <= WAIT_BUSY;
                    end else if (!own_valid) begin
                        // Owner went quiet mid-message: revoke after STALL_MAX
                        // idle cycles; the message is treated as truncated.
                        if (stall_cnt_q >= STALL_LIM) begin
                            rr_ptr_q <= owner_q;
                            grant_q  <= '0;
                            state_q  <= IDLE;
                        end else begin
                            stall_cnt_q <= stall_cnt_q + 10'd1;
                        end
                    end
                end

                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_flag_q || (burst_cnt_q >= BURST_LIM)) begin
                            rr_ptr_q <= owner_q;
                            grant_q  <= '0;
                            state_q  <= IDLE;
                        end else begin
                            state_q <= SEND;
                        end
                    end
                end

                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign active   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (N_REQ=2, MAX_BURST=4, STALL_MAX=8).
// Two queue-backed requesters and a transmitter model that stays busy for
// BUSY_LEN cycles per start drive the DUT; every tx_start is logged with its
// byte, grant and cycle number, and each scenario task checks the log.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int unsigned N_REQ     = 2;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned STALL_MAX = 8;
    localparam int          BUSY_LEN  = 10;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_start;
    logic                    tx_busy;
    logic [N_REQ-1:0]        grant;
    logic                    active;

    int          npass  = 0;
    int          ntotal = 0;
    int          cyc    = 0;
    int          busy_cnt = 0;
    logic        ext_busy = 1'b0;
    logic [1:0]  en       = 2'b00;
    logic [1:0]  acc_prev = 2'b00;

    // {last, data} per requester
    logic [8:0]  q0 [$];
    logic [8:0]  q1 [$];

    logic [7:0]  out_data  [$];
    int          out_cyc   [$];
    logic [1:0]  out_grant [$];

    always #5 clk = ~clk;

    assign tx_busy = (busy_cnt != 0) || ext_busy;

    uart_tx_arbiter #(
        .N_REQ    (N_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST),
        .STALL_MAX(STALL_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .grant    (grant),
        .active   (active)
    );

    // Requesters, transmitter model and start logger, all stepped at negedge.
    // req_ready is sampled at negedge+4 (after any mid-cycle stimulus change)
    // and the accepted byte is popped at the following negedge.
    initial begin
        logic [8:0] h0, h1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                busy_cnt = 0;
                acc_prev = 2'b00;
            end else begin
                if (tx_start === 1'b1) begin
                    out_data.push_back(tx_data);
                    out_cyc.push_back(cyc);
                    out_grant.push_back(grant);
                    busy_cnt = BUSY_LEN;
                end else if (busy_cnt != 0) begin
                    busy_cnt--;
                end
                if (acc_prev[0] && q0.size() != 0) void'(q0.pop_front());
                if (acc_prev[1] && q1.size() != 0) void'(q1.pop_front());
            end
            h0 = (q0.size() != 0) ? q0[0] : 9'h000;
            h1 = (q1.size() != 0) ? q1[0] : 9'h000;
            req_valid = {en[1] && (q1.size() != 0), en[0] && (q0.size() != 0)};
            req_data  = {h1[7:0], h0[7:0]};
            req_last  = {h1[8], h0[8]};
            #4;
            acc_prev = req_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_log();
        out_data.delete();
        out_cyc.delete();
        out_grant.delete();
    endtask

    // Waits (bounded) for empty queues, no grant and an idle transmitter.
    task automatic wait_quiet(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (q0.size() == 0 && q1.size() == 0 && active === 1'b0 && busy_cnt == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        ntotal++; if (grant !== 2'b00) $display("FAIL reset_grant got %b expected 00", grant); else npass++;
        ntotal++; if (active !== 1'b0) $display("FAIL reset_active got %b expected 0", active); else npass++;
        ntotal++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start got %b expected 0", tx_start); else npass++;
        ntotal++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h expected 00", tx_data); else npass++;
        ntotal++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got %b expected 00", req_ready); else npass++;
        en = 2'b11;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_single_message();
        logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
        logic [7:0] got;
        int t0, gap;
        bit ok;
        clear_log();
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b1, 8'h43});
        t0 = cyc;
        wait_quiet(300, ok);
        ntotal++; if (!ok) $display("FAIL single_timeout got busy expected quiet"); else npass++;
        ntotal++; if (out_data.size() != 3) $display("FAIL single_count got %0d expected 3", out_data.size()); else npass++;
        for (int i = 0; i < 3; i++) begin
            got = (i < out_data.size()) ? out_data[i] : 8'hxx;
            ntotal++; if (got !== exp[i]) $display("FAIL single_byte%0d got %h expected %h", i, got, exp[i]); else npass++;
            got = (i < out_grant.size()) ? 8'(out_grant[i]) : 8'hxx;
            ntotal++; if (got !== 8'h01) $display("FAIL single_grant%0d got %h expected 01", i, got); else npass++;
        end
        gap = (out_cyc.size() >= 1) ? out_cyc[0] - t0 : -1;
        ntotal++; if (gap != 3) $display("FAIL single_latency got %0d expected 3", gap); else npass++;
        gap = (out_cyc.size() >= 2) ? out_cyc[1] - out_cyc[0] : -1;
        ntotal++; if (gap != 12) $display("FAIL single_gap01 got %0d expected 12", gap); else npass++;
        gap = (out_cyc.size() >= 3) ? out_cyc[2] - out_cyc[1] : -1;
        ntotal++; if (gap != 12) $display("FAIL single_gap12 got %0d expected 12", gap); else npass++;
        ntotal++; if (grant !== 2'b00) $display("FAIL single_grant_end got %b expected 00", grant); else npass++;
        ntotal++; if (tx_data !== 8'h43) $display("FAIL single_tx_data_hold got %h expected 43", tx_data); else npass++;
    endtask

    task automatic test_two_requesters();
        logic [7:0] exp_d [6] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h22};
        logic [1:0] exp_g [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
        logic [7:0] gd;
        logic [1:0] gg;
        bit ok;
        // Restart from reset so requester 0 has first priority.
        rst = 1'b0;
        clear_log();
        q0.push_back({1'b0, 8'h10});
        q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b0, 8'h20});
        q1.push_back({1'b1, 8'h21});
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        wait_quiet(300, ok);
        ntotal++; if (!ok) $display("FAIL two_timeout1 got busy expected quiet"); else npass++;
        q0.push_back({1'b1, 8'h12});
        q1.push_back({1'b1, 8'h22});
        wait_quiet(300, ok);
        ntotal++; if (!ok) $display("FAIL two_timeout2 got busy expected quiet"); else npass++;
        ntotal++; if (out_data.size() != 6) $display("FAIL two_count got %0d expected 6", out_data.size()); else npass++;
        for (int i = 0; i < 6; i++) begin
            gd = (i < out_data.size()) ? out_data[i] : 8'hxx;
            gg = (i < out_grant.size()) ? out_grant[i] : 2'bxx;
            ntotal++; if (gd !== exp_d[i]) $display("FAIL two_byte%0d got %h expected %h", i, gd, exp_d[i]); else npass++;
            ntotal++; if (gg !== exp_g[i]) $display("FAIL two_grant%0d got %b expected %b", i, gg, exp_g[i]); else npass++;
        end
    endtask

    task automatic test_burst_limit();
        logic [7:0] exp_d [11] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'hA0, 8'hA1,
                                   8'h84, 8'h85, 8'h86, 8'h87, 8'hB0};
        logic [1:0] exp_g [11] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10,
                                   2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        logic [7:0] gd;
        logic [1:0] gg;
        bit ok;
        clear_log();
        for (int i = 0; i < 8; i++) begin
            q0.push_back({(i == 7), 8'(8'h80 + i)});
        end
        q1.push_back({1'b0, 8'hA0});
        q1.push_back({1'b1, 8'hA1});
        q1.push_back({1'b1, 8'hB0});
        wait_quiet(600, ok);
        ntotal++; if (!ok) $display("FAIL burst_timeout got busy expected quiet"); else npass++;
        ntotal++; if (out_data.size() != 11) $display("FAIL burst_count got %0d expected 11", out_data.size()); else npass++;
        for (int i = 0; i < 11; i++) begin
            gd = (i < out_data.size()) ? out_data[i] : 8'hxx;
            gg = (i < out_grant.size()) ? out_grant[i] : 2'bxx;
            ntotal++; if (gd !== exp_d[i]) $display("FAIL burst_byte%0d got %h expected %h", i, gd, exp_d[i]); else npass++;
            ntotal++; if (gg !== exp_g[i]) $display("FAIL burst_grant%0d got %b expected %b", i, gg, exp_g[i]); else npass++;
        end
    endtask

    task automatic test_stall_timeout();
        logic [7:0] gd;
        logic [1:0] gg;
        int gap;
        bit ok;
        clear_log();
        q0.push_back({1'b0, 8'h55});
        q1.push_back({1'b1, 8'h66});
        wait_quiet(300, ok);
        ntotal++; if (!ok) $display("FAIL stall_timeout got busy expected quiet"); else npass++;
        ntotal++; if (out_data.size() != 2) $display("FAIL stall_count got %0d expected 2", out_data.size()); else npass++;
        gd = (out_data.size() >= 2) ? out_data[1] : 8'hxx;
        gg = (out_grant.size() >= 2) ? out_grant[1] : 2'bxx;
        ntotal++; if (gd !== 8'h66) $display("FAIL stall_next_byte got %h expected 66", gd); else npass++;
        ntotal++; if (gg !== 2'b10) $display("FAIL stall_next_grant got %b expected 10", gg); else npass++;
        // 11 busy/handshake cycles + 8 stall cycles + IDLE + accept
        gap = (out_cyc.size() >= 2) ? out_cyc[1] - out_cyc[0] : -1;
        ntotal++; if (gap != 21) $display("FAIL stall_release_gap got %0d expected 21", gap); else npass++;
    endtask

    task automatic test_busy_hold();
        logic [7:0] gd;
        int t1, gap;
        bit ok;
        clear_log();
        ext_busy = 1'b1;
        q0.push_back({1'b1, 8'h77});
        repeat (20) @(negedge clk);
        #2;
        ntotal++; if (grant !== 2'b01) $display("FAIL busy_grant got %b expected 01", grant); else npass++;
        ntotal++; if (active !== 1'b1) $display("FAIL busy_active got %b expected 1", active); else npass++;
        ntotal++; if (req_ready !== 2'b00) $display("FAIL busy_req_ready got %b expected 00", req_ready); else npass++;
        ntotal++; if (out_data.size() != 0) $display("FAIL busy_no_start got %0d expected 0", out_data.size()); else npass++;
        ext_busy = 1'b0;
        t1 = cyc;
        wait_quiet(200, ok);
        ntotal++; if (!ok) $display("FAIL busy_timeout got busy expected quiet"); else npass++;
        gd = (out_data.size() >= 1) ? out_data[0] : 8'hxx;
        ntotal++; if (gd !== 8'h77) $display("FAIL busy_byte got %h expected 77", gd); else npass++;
        gap = (out_cyc.size() >= 1) ? out_cyc[0] - t1 : -1;
        ntotal++; if (gap != 1) $display("FAIL busy_start_delay got %0d expected 1", gap); else npass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] gd;
        logic [1:0] gg;
        bit ok;
        clear_log();
        q0.push_back({1'b0, 8'h31});
        q0.push_back({1'b1, 8'h32});
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #2;
            if (out_data.size() >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        ntotal++; if (!ok) $display("FAIL rstmid_first_start got none expected start"); else npass++;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        ntotal++; if (grant !== 2'b00) $display("FAIL rstmid_grant got %b expected 00", grant); else npass++;
        ntotal++; if (active !== 1'b0) $display("FAIL rstmid_active got %b expected 0", active); else npass++;
        ntotal++; if (tx_start !== 1'b0) $display("FAIL rstmid_tx_start got %b expected 0", tx_start); else npass++;
        ntotal++; if (req_ready !== 2'b00) $display("FAIL rstmid_req_ready got %b expected 00", req_ready); else npass++;
        ntotal++; if (tx_data !== 8'h00) $display("FAIL rstmid_tx_data got %h expected 00", tx_data); else npass++;
        q1.push_back({1'b1, 8'h99});
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        wait_quiet(300, ok);
        ntotal++; if (!ok) $display("FAIL rstmid_timeout got busy expected quiet"); else npass++;
        ntotal++; if (out_data.size() != 3) $display("FAIL rstmid_count got %0d expected 3", out_data.size()); else npass++;
        gd = (out_data.size() >= 2) ? out_data[1] : 8'hxx;
        gg = (out_grant.size() >= 2) ? out_grant[1] : 2'bxx;
        ntotal++; if (gd !== 8'h32) $display("FAIL rstmid_first_after got %h expected 32", gd); else npass++;
        ntotal++; if (gg !== 2'b01) $display("FAIL rstmid_first_grant got %b expected 01", gg); else npass++;
        gd = (out_data.size() >= 3) ? out_data[2] : 8'hxx;
        ntotal++; if (gd !== 8'h99) $display("FAIL rstmid_second_after got %h expected 99", gd); else npass++;
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        test_reset();
        test_single_message();
        test_two_requesters();
        test_burst_limit();
        test_stall_timeout();
        test_busy_hold();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
